// File: rtl/onehot_ring_seq.sv
// onehot_ring_seq: registered one-hot ring sequencer with load, wrap pulse,
// step counter and illegal-state recovery.
//
// Ports:
//   clk            rising-edge clock
//   rst            synchronous active-high reset
//   step_in        advance the ring one position this cycle
//   dir_in         0 = forward (rotate-left), 1 = reverse (rotate-right)
//   load_in        load load_val into the ring (wins over step_in)
//   load_val       value to load; a non-one-hot value forces INIT and sets err_out
//   state_out      registered ring state
//   next_state_out combinational rotation of state_out per dir_in
//   wrap_out       registered 1-cycle pulse when a step crosses the ring end
//   step_cnt       count of accepted steps
//   err_out        sticky illegal-load / illegal-state flag, cleared by rst
//
// Build option: define RING_SEQ_SAT_CNT_EN to make step_cnt saturate at
// all-ones instead of wrapping to zero.

module onehot_ring_seq #(
    parameter int               WIDTH = 3,
    parameter logic [WIDTH-1:0] INIT  = WIDTH'(1),
    parameter int               CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step_in,
    input  logic             dir_in,
    input  logic             load_in,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] state_out,
    output logic [WIDTH-1:0] next_state_out,
    output logic             wrap_out,
    output logic [CNT_W-1:0] step_cnt,
    output logic             err_out
);

    function automatic logic is_onehot(input logic [WIDTH-1:0] v);
        return (v != '0) && ((v & (v - WIDTH'(1))) == '0);
    endfunction

    logic [WIDTH-1:0] rot_fwd;
    logic [WIDTH-1:0] rot_rev;
    logic             state_ok;
    logic             load_ok;
    logic             crosses_end;
    logic [CNT_W-1:0] cnt_nxt;

    always_comb begin
        rot_fwd        = {state_out[WIDTH-2:0], state_out[WIDTH-1]};
        rot_rev        = {state_out[0], state_out[WIDTH-1:1]};
        next_state_out = dir_in ? rot_rev : rot_fwd;
        state_ok       = is_onehot(state_out);
        load_ok        = is_onehot(load_val);
        // The hot bit leaves the ring end in the stepping direction.
        crosses_end    = dir_in ? state_out[0] : state_out[WIDTH-1];
    end

`ifdef RING_SEQ_SAT_CNT_EN
    assign cnt_nxt = (step_cnt == '1) ? step_cnt : step_cnt + CNT_W'(1);
`else
    assign cnt_nxt = step_cnt + CNT_W'(1);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_out <= INIT;
            wrap_out  <= 1'b0;
            step_cnt  <= '0;
            err_out   <= 1'b0;
        end else begin
            wrap_out <= 1'b0;
            if (load_in) begin
                if (load_ok) begin
                    state_out <= load_val;
                end else begin
                    state_out <= INIT;
                    err_out   <= 1'b1;
                end
            end else if (step_in) begin
                step_cnt <= cnt_nxt;
                if (state_ok) begin
                    state_out <= next_state_out;
                    wrap_out  <= crosses_end;
                end else begin
                    // Corrupted ring: resynchronise instead of rotating garbage.
                    state_out <= INIT;
                    err_out   <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_onehot_ring_seq.sv
// tb_onehot_ring_seq: directed self-checking bench for onehot_ring_seq
// (WIDTH=3, INIT=3'b001, CNT_W=8).

module tb_onehot_ring_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       step_in = 1'b0;
    logic       dir_in = 1'b0;
    logic       load_in = 1'b0;
    logic [2:0] load_val = 3'b000;
    logic [2:0] state_out;
    logic [2:0] next_state_out;
    logic       wrap_out;
    logic [7:0] step_cnt;
    logic       err_out;

    int n_cmp = 0;
    int n_bad = 0;

    onehot_ring_seq #(
        .WIDTH(3),
        .INIT (3'b001),
        .CNT_W(8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .step_in       (step_in),
        .dir_in        (dir_in),
        .load_in       (load_in),
        .load_val      (load_val),
        .state_out     (state_out),
        .next_state_out(next_state_out),
        .wrap_out      (wrap_out),
        .step_cnt      (step_cnt),
        .err_out       (err_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step_in  = 1'b0;
        load_in  = 1'b0;
        load_val = 3'b000;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        dir_in = 1'b0;
        idle();
        tick();
        rst = 1'b0;
        n_cmp++;
        if (state_out !== 3'b001) begin
            n_bad++;
            $display("FAIL reset_state got %b want 001", state_out);
        end
        n_cmp++;
        if (step_cnt !== 8'd0) begin
            n_bad++;
            $display("FAIL reset_cnt got %0d want 0", step_cnt);
        end
        n_cmp++;
        if (wrap_out !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_wrap got %b want 0", wrap_out);
        end
        n_cmp++;
        if (err_out !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_err got %b want 0", err_out);
        end
        n_cmp++;
        if (next_state_out !== 3'b010) begin
            n_bad++;
            $display("FAIL reset_preview got %b want 010", next_state_out);
        end
    endtask

    task automatic test_forward();
        logic [2:0] exp_st [3];
        logic       exp_wr [3];
        exp_st[0] = 3'b010; exp_wr[0] = 1'b0;
        exp_st[1] = 3'b100; exp_wr[1] = 1'b0;
        exp_st[2] = 3'b001; exp_wr[2] = 1'b1;
        dir_in  = 1'b0;
        step_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (state_out !== exp_st[i]) begin
                n_bad++;
                $display("FAIL fwd_state[%0d] got %b want %b", i, state_out, exp_st[i]);
            end
            n_cmp++;
            if (wrap_out !== exp_wr[i]) begin
                n_bad++;
                $display("FAIL fwd_wrap[%0d] got %b want %b", i, wrap_out, exp_wr[i]);
            end
        end
        idle();
        n_cmp++;
        if (step_cnt !== 8'd3) begin
            n_bad++;
            $display("FAIL fwd_cnt got %0d want 3", step_cnt);
        end
        tick();
        n_cmp++;
        if (wrap_out !== 1'b0 || state_out !== 3'b001) begin
            n_bad++;
            $display("FAIL fwd_hold got st=%b wr=%b want st=001 wr=0", state_out, wrap_out);
        end
    endtask

    task automatic test_reverse();
        dir_in  = 1'b1;
        step_in = 1'b1;
        tick();
        n_cmp++;
        if (state_out !== 3'b100 || wrap_out !== 1'b1) begin
            n_bad++;
            $display("FAIL rev_step1 got st=%b wr=%b want st=100 wr=1", state_out, wrap_out);
        end
        tick();
        n_cmp++;
        if (state_out !== 3'b010 || wrap_out !== 1'b0) begin
            n_bad++;
            $display("FAIL rev_step2 got st=%b wr=%b want st=010 wr=0", state_out, wrap_out);
        end
        idle();
        n_cmp++;
        if (next_state_out !== 3'b001) begin
            n_bad++;
            $display("FAIL rev_preview got %b want 001", next_state_out);
        end
        dir_in = 1'b0;
        #1;
        n_cmp++;
        if (next_state_out !== 3'b100) begin
            n_bad++;
            $display("FAIL fwd_preview got %b want 100", next_state_out);
        end
        n_cmp++;
        if (step_cnt !== 8'd5) begin
            n_bad++;
            $display("FAIL rev_cnt got %0d want 5", step_cnt);
        end
    endtask

    task automatic test_load();
        dir_in   = 1'b0;
        step_in  = 1'b1;
        load_in  = 1'b1;
        load_val = 3'b100;
        #1;
        n_cmp++;
        if (next_state_out !== 3'b100) begin
            n_bad++;
            $display("FAIL load_preview got %b want 100", next_state_out);
        end
        tick();
        n_cmp++;
        if (state_out !== 3'b100 || step_cnt !== 8'd5 || wrap_out !== 1'b0) begin
            n_bad++;
            $display("FAIL load_ok got st=%b cnt=%0d wr=%b want st=100 cnt=5 wr=0",
                     state_out, step_cnt, wrap_out);
        end
        n_cmp++;
        if (err_out !== 1'b0) begin
            n_bad++;
            $display("FAIL load_ok_err got %b want 0", err_out);
        end
        load_val = 3'b110;
        tick();
        n_cmp++;
        if (state_out !== 3'b001 || err_out !== 1'b1 || step_cnt !== 8'd5) begin
            n_bad++;
            $display("FAIL load_bad got st=%b err=%b cnt=%0d want st=001 err=1 cnt=5",
                     state_out, err_out, step_cnt);
        end
        load_in = 1'b0;
        tick();
        tick();
        n_cmp++;
        if (state_out !== 3'b100 || err_out !== 1'b1 || step_cnt !== 8'd7) begin
            n_bad++;
            $display("FAIL err_sticky got st=%b err=%b cnt=%0d want st=100 err=1 cnt=7",
                     state_out, err_out, step_cnt);
        end
        idle();
        load_in  = 1'b1;
        load_val = 3'b000;
        tick();
        idle();
        n_cmp++;
        if (state_out !== 3'b001 || err_out !== 1'b1) begin
            n_bad++;
            $display("FAIL load_zero got st=%b err=%b want st=001 err=1", state_out, err_out);
        end
    endtask

    task automatic test_count_wrap();
        logic [7:0] want_cnt;
`ifdef RING_SEQ_SAT_CNT_EN
        want_cnt = 8'd255;
`else
        want_cnt = 8'd0;
`endif
        do_reset();
        dir_in  = 1'b0;
        step_in = 1'b1;
        for (int i = 0; i < 255; i++) tick();
        n_cmp++;
        if (step_cnt !== 8'd255 || state_out !== 3'b001) begin
            n_bad++;
            $display("FAIL cnt_255 got cnt=%0d st=%b want cnt=255 st=001", step_cnt, state_out);
        end
        tick();
        idle();
        n_cmp++;
        if (step_cnt !== want_cnt) begin
            n_bad++;
            $display("FAIL cnt_256 got %0d want %0d", step_cnt, want_cnt);
        end
        n_cmp++;
        if (state_out !== 3'b010) begin
            n_bad++;
            $display("FAIL state_256 got %b want 010", state_out);
        end
    endtask

    task automatic test_reset_mid();
        load_in  = 1'b1;
        load_val = 3'b011;
        tick();
        load_in = 1'b0;
        step_in = 1'b1;
        tick();
        n_cmp++;
        if (err_out !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_setup_err got %b want 1", err_out);
        end
        rst      = 1'b1;
        step_in  = 1'b1;
        load_in  = 1'b1;
        load_val = 3'b010;
        tick();
        rst = 1'b0;
        idle();
        n_cmp++;
        if (state_out !== 3'b001 || step_cnt !== 8'd0 ||
            err_out !== 1'b0 || wrap_out !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_mid got st=%b cnt=%0d err=%b wr=%b want 001/0/0/0",
                     state_out, step_cnt, err_out, wrap_out);
        end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_reverse();
        test_load();
        test_count_wrap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
